// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and the
// buffered external request slot.
`timescale 1ns/1ps
package dmem_arbiter_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE,
    RESP
  } dmem_arb_state_t;

  // Slot widths follow the pipeline's data memory.
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [2:0]             funct3;
  } ext_mem_req_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Ownership mux for the data-memory port: the buffered external request
// when ext_owner is set, otherwise the MEM-stage access passes straight through.
`timescale 1ns/1ps
module dmem_port_mux
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int DM_ADDRESS = DMEM_ADDR_W
) (
  input  logic                  ext_owner,
  input  ext_mem_req_t          slot,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  assign mem_rd     = ext_owner ? !slot.we    : core_rd;
  assign mem_wr     = ext_owner ? slot.we     : core_wr;
  assign mem_addr   = ext_owner ? slot.addr   : core_addr;
  assign mem_wdata  = ext_owner ? slot.wdata  : core_wdata;
  assign mem_funct3 = ext_owner ? slot.funct3 : core_funct3;

  // The MEM stage never sees data that belongs to the external requester.
  assign core_rdata = ext_owner ? '0 : mem_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage (priority)
// and an external requester, forcing one external access after MAX_WAIT blocked cycles.
`timescale 1ns/1ps
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int DM_ADDRESS = DMEM_ADDR_W,
  parameter int MAX_WAIT   = 8,
  parameter int WAIT_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic                  ext_we,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  input  logic [2:0]            ext_funct3,
  output logic                  ext_rvalid,
  output logic [DATA_W-1:0]     ext_rdata,
  input  logic                  ext_rready,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  ext_owner
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  dmem_arb_state_t   state;
  ext_mem_req_t      slot;
  logic [WAIT_W-1:0] wait_cnt;
  logic              core_req;
  logic              ext_forced;
  logic              ext_issue;

  assign core_req   = core_rd | core_wr;
  assign ext_forced = (state == FORCE);
  assign ext_issue  = ext_forced || (state == PEND && !core_req);

  assign ext_owner  = ext_issue;
  assign core_stall = ext_forced && core_req;
  assign ext_ready  = (state == IDLE) && reset;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      slot       <= '0;
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ext_valid) begin
            slot     <= '{we: ext_we, addr: ext_addr, wdata: ext_wdata, funct3: ext_funct3};
            wait_cnt <= '0;
            state    <= PEND;
          end
        end
        PEND, FORCE: begin
          if (ext_issue) begin
            ext_rdata  <= slot.we ? '0 : mem_rdata;
            ext_rvalid <= 1'b1;
            state      <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= FORCE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (ext_rready) begin
            ext_rvalid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Core enables are masked during reset so no stray access reaches memory.
  dmem_port_mux #(
    .DATA_W     (DATA_W),
    .DM_ADDRESS (DM_ADDRESS)
  ) u_port_mux (
    .ext_owner   (ext_owner),
    .slot        (slot),
    .core_rd     (core_rd & reset),
    .core_wr     (core_wr & reset),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_funct3 (core_funct3),
    .core_rdata  (core_rdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_funct3  (mem_funct3),
    .mem_rdata   (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter against a cycle-count reference
// model of the arbitration rules and a behavioural data memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int DATA_W   = 32;
  localparam int AW       = 9;
  localparam int MAX_WAIT = 8;
  localparam int WAIT_W   = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [2:0]    funct3;
  } req_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_rd, core_wr;
  logic [AW-1:0]     core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [2:0]        core_funct3;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              ext_valid, ext_ready, ext_we;
  logic [AW-1:0]     ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [2:0]        ext_funct3;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rready;
  logic              mem_rd, mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;
  logic              ext_owner;

  dmem_arbiter #(
    .DATA_W (DATA_W), .DM_ADDRESS (AW), .MAX_WAIT (MAX_WAIT), .WAIT_W (WAIT_W)
  ) dut (
    .clk (clk), .reset (reset),
    .core_rd (core_rd), .core_wr (core_wr), .core_addr (core_addr),
    .core_wdata (core_wdata), .core_funct3 (core_funct3),
    .core_rdata (core_rdata), .core_stall (core_stall),
    .ext_valid (ext_valid), .ext_ready (ext_ready), .ext_we (ext_we),
    .ext_addr (ext_addr), .ext_wdata (ext_wdata), .ext_funct3 (ext_funct3),
    .ext_rvalid (ext_rvalid), .ext_rdata (ext_rdata), .ext_rready (ext_rready),
    .mem_rd (mem_rd), .mem_wr (mem_wr), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_funct3 (mem_funct3), .mem_rdata (mem_rdata),
    .ext_owner (ext_owner)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with combinational read; preloaded through pl_*.
  logic [31:0]   tb_mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_addr] <= pl_data;
    else if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
  end

  // Reference model state
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        m_busy = 1'b0;
  logic        m_pending = 1'b0;
  logic        m_resp = 1'b0;
  int          m_acc_cyc = 0;
  req_t        m_req;
  logic        hold_core = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance model.
  task automatic run_cycle(input logic c_rd, input logic c_wr, input logic [AW-1:0] c_addr,
                           input logic [31:0] c_wdata, input logic e_valid, input logic e_we,
                           input logic [AW-1:0] e_addr, input logic [31:0] e_wdata,
                           input logic e_rready);
    logic exp_ready, forced, issue, creq;
    if (!hold_core) begin
      core_rd     = c_rd;
      core_wr     = c_wr;
      core_addr   = c_addr;
      core_wdata  = c_wdata;
      core_funct3 = 3'($urandom);
    end
    ext_valid  = e_valid;
    ext_we     = e_we;
    ext_addr   = e_addr;
    ext_wdata  = e_wdata;
    ext_funct3 = 3'($urandom);
    ext_rready = e_rready;
    #1;
    creq      = core_rd | core_wr;
    exp_ready = !m_busy;
    forced    = m_pending && (cyc == m_acc_cyc + 1 + MAX_WAIT);
    issue     = m_pending && (forced || !creq);
    check("ext_ready", 32'(ext_ready), 32'(exp_ready));
    check("ext_owner", 32'(ext_owner), 32'(issue));
    check("core_stall", 32'(core_stall), 32'(forced && creq));
    check("ext_rvalid", 32'(ext_rvalid), 32'(m_resp));
    if (issue) begin
      check("mem_rd_ext", 32'(mem_rd), 32'(!m_req.we));
      check("mem_wr_ext", 32'(mem_wr), 32'(m_req.we));
      check("mem_addr_ext", 32'(mem_addr), 32'(m_req.addr));
      check("mem_funct3_ext", 32'(mem_funct3), 32'(m_req.funct3));
      if (m_req.we) check("mem_wdata_ext", mem_wdata, m_req.wdata);
    end else begin
      check("mem_rd_core", 32'(mem_rd), 32'(core_rd));
      check("mem_wr_core", 32'(mem_wr), 32'(core_wr));
      check("mem_addr_core", 32'(mem_addr), 32'(core_addr));
      check("mem_funct3_core", 32'(mem_funct3), 32'(core_funct3));
      if (core_wr) check("mem_wdata_core", mem_wdata, core_wdata);
    end
    check("core_rdata", core_rdata, issue ? 32'h0 : ref_mem[core_addr]);

    if (issue) begin
      exp_q.push_back(m_req.we ? 32'h0 : ref_mem[m_req.addr]);
      if (m_req.we) ref_mem[m_req.addr] = m_req.wdata;
      m_pending = 1'b0;
    end else if (core_wr) begin
      ref_mem[core_addr] = core_wdata;
    end
    if (m_resp && ext_rready) begin
      m_resp = 1'b0;
      m_busy = 1'b0;
    end
    if (issue) m_resp = 1'b1;
    if (exp_ready && ext_valid) begin
      m_req     = '{we: ext_we, addr: ext_addr, wdata: ext_wdata, funct3: ext_funct3};
      m_busy    = 1'b1;
      m_pending = 1'b1;
      m_acc_cyc = cyc;
    end
    hold_core = forced && creq;
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_cycle(input int p_core, input int p_ext, input int p_rr);
    logic rq, wr;
    rq = ($urandom_range(0, 99) < p_core);
    wr = rq && ($urandom_range(0, 2) == 0);
    run_cycle(rq && !wr, wr, AW'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 99) < p_ext, 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 31)), $urandom, $urandom_range(0, 99) < p_rr);
  endtask

  // Monitor: pops the scoreboard on every response handshake, checks hold stability.
  logic        held = 1'b0;
  logic [31:0] held_data;
  always @(negedge clk) begin
    #2;
    if (!reset || !ext_rvalid) begin
      held = 1'b0;
    end else begin
      if (held) check("rdata_stable", ext_rdata, held_data);
      if (ext_rready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp at cycle %0d: got 0x%08h, expected no response", cyc, ext_rdata);
        end else begin
          check("ext_rdata", ext_rdata, exp_q.pop_front());
        end
        held = 1'b0;
      end else begin
        held      = 1'b1;
        held_data = ext_rdata;
      end
    end
  end

  initial begin
    reset = 1'b0;
    {core_rd, core_wr, ext_valid, ext_we, ext_rready} = '0;
    core_addr = '0; core_wdata = '0; core_funct3 = '0;
    ext_addr = '0; ext_wdata = '0; ext_funct3 = '0;

    for (int a = 0; a < (1 << AW); a++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = AW'(a);
      pl_data = (a == 'h010) ? 32'hDEADBEEF : (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
      ref_mem[a] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;

    // Reset state with the core trying to access memory
    core_rd = 1'b1; core_wr = 1'b1;
    #1;
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_owner", 32'(ext_owner), 32'h0);
    check("rst_stall", 32'(core_stall), 32'h0);
    check("rst_rvalid", 32'(ext_rvalid), 32'h0);
    check("rst_rdata", ext_rdata, 32'h0);
    core_rd = 1'b0; core_wr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_ready", 32'(ext_ready), 32'h1);
    @(negedge clk);

    // Unblocked ext read of 0x010
    run_cycle(0, 0, 0, 0, 1, 0, 9'h010, 0, 1);
    repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Core reads every cycle: ext write gets forced after MAX_WAIT cycles
    run_cycle(1, 0, AW'($urandom_range(0, 15)), 0, 1, 1, 9'h020, 32'h12345678, 1);
    repeat (12) run_cycle(1, 0, AW'($urandom_range(0, 15)), 0, 0, 0, 0, 0, 1);
    run_cycle(1, 0, 9'h020, 0, 0, 0, 0, 0, 1);

    // Core accesses every other cycle
    for (int i = 0; i < 10; i++)
      run_cycle(i % 2 == 0, 0, AW'($urandom_range(0, 31)), 0, i == 0, 0,
                AW'($urandom_range(0, 31)), 0, 1);

    // Response held by ext_rready low while the core keeps working
    run_cycle(0, 0, 0, 0, 1, 0, 9'h011, 0, 0);
    repeat (7) rand_cycle(70, 100, 0);
    repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Core write and ext capture in the same IDLE cycle
    run_cycle(0, 1, 9'h030, 32'hCAFEF00D, 1, 0, 9'h030, 0, 1);
    run_cycle(1, 0, 9'h031, 0, 0, 0, 0, 0, 1);
    repeat (4) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic at several core loads
    repeat (150) rand_cycle(50, 40, 60);
    repeat (150) rand_cycle(95, 50, 70);
    repeat (100) rand_cycle(20, 60, 40);
    repeat (10) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset while PEND at wait_cnt = 3: the request is dropped
    run_cycle(1, 0, 9'h005, 0, 1, 0, 9'h006, 0, 1);
    repeat (3) run_cycle(1, 0, 9'h005, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(ext_rvalid), 32'h0);
    check("mid_rst_owner", 32'(ext_owner), 32'h0);
    check("mid_rst_stall", 32'(core_stall), 32'h0);
    check("mid_rst_mem_rd", 32'(mem_rd), 32'h0);
    check("mid_rst_mem_wr", 32'(mem_wr), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    m_busy = 1'b0; m_pending = 1'b0; m_resp = 1'b0; hold_core = 1'b0;
    #1;
    check("mid_rel_ready", 32'(ext_ready), 32'h1);
    @(negedge clk);
    repeat (15) rand_cycle(50, 0, 100);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port between the pipeline MEM stage and an external requester (loader/debug) that uses a valid/ready handshake. The MEM stage normally has priority. A bounded-wait counter forces one external access, stalling the pipeline for one cycle, so the external requester cannot starve. The block sits between the EX/MEM pipeline register outputs and the data memory instance.

Parameters:
DATA_W, 32, data width
DM_ADDRESS, 9, data-memory address width
MAX_WAIT, 8, cycles a pending external request may be blocked by the core before it is forced (≥1)
WAIT_W, 4, width of the wait counter (must hold MAX_WAIT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
core_rd  in  1  MEM-stage read enable
core_wr  in  1  MEM-stage write enable
core_addr  in  DM_ADDRESS  MEM-stage address
core_wdata  in  DATA_W  MEM-stage write data
core_funct3  in  3  MEM-stage access size/sign
core_rdata  out  DATA_W  read data returned to MEM stage
core_stall  out  1  pipeline freeze request (holds PC, IF/ID, ID/EX, EX/MEM; bubbles MEM/WB)
ext_valid  in  1  external request valid
ext_ready  out  1  external request accepted
ext_we  in  1  1 = write, 0 = read
ext_addr  in  DM_ADDRESS  external address
ext_wdata  in  DATA_W  external write data
ext_funct3  in  3  external access size
ext_rvalid  out  1  external response valid
ext_rdata  out  DATA_W  external read data (0 for writes)
ext_rready  in  1  external response consumed
mem_rd, mem_wr  out  1 each  data-memory enables
mem_addr  out  DM_ADDRESS  data-memory address
mem_wdata  out  DATA_W  data-memory write data
mem_funct3  out  3  data-memory size
mem_rdata  in  DATA_W  data-memory read data (combinational read)
ext_owner  out  1  1 when the external requester drives the memory this cycle

Behaviour:
- core_req = core_rd | core_wr.
- FSM states: IDLE, PEND, FORCE, RESP. Registered state; request slot holds we/addr/wdata/funct3.
- IDLE:
  - ext_ready = 1.
  - ext_valid & ext_ready captures the request into the slot, clears wait_cnt and moves to PEND.
- PEND:
  - If !core_req: the ext access issues this cycle (ext_owner = 1). mem_rdata is registered into ext_rdata (writes register 0). Next state is RESP.
  - Else if wait_cnt == MAX_WAIT-1: next state is FORCE.
  - Else: wait_cnt increments.
- FORCE:
  - The ext access issues unconditionally (ext_owner = 1). core_stall = core_req. Next state is RESP.
  - The core access is not issued and is replayed the next cycle because the pipeline is frozen.
- RESP:
  - ext_rvalid = 1 with ext_rdata stable.
  - ext_rready moves to IDLE, so the next acceptance is at the earliest the following cycle.
  - The core has full priority in RESP and IDLE.
- Memory mux:
  - ext_owner selects slot fields; otherwise the core fields pass through combinationally.
  - core_rdata = mem_rdata when !ext_owner, else 0.
- core_stall is asserted only in FORCE with core_req. It is never asserted in any other state.
- Latency:
  - Unblocked ext request: accept at cycle T, issue at T+1, ext_rvalid at T+2.
  - Fully blocked: issue at T+1+MAX_WAIT.
- Reset (async, active-low, also mid-transaction): state = IDLE, wait_cnt = 0, slot = 0, ext_rdata = 0, ext_rvalid = 0.
  - ext_ready is 1 once released.
  - ext_owner, core_stall, mem_rd and mem_wr are 0 while reset is asserted.
  - An in-flight ext request is dropped without a response.
- Simultaneous core_req and ext_valid in IDLE: the core is served and the ext request is captured the same cycle.
- wait_cnt saturates and never wraps. It is used only in PEND.

Decomposition:
- Shared package (the existing pipeline package) adds:
  - typedef enum logic [1:0] dmem_arb_state_t {IDLE, PEND, FORCE, RESP};
  - typedef struct ext_mem_req_t {we, addr, wdata, funct3}.
- One natural sub-module: dmem_port_mux, the combinational ownership mux for mem_* and core_rdata. The FSM and counter stay in the top module.

Test Plan:
- Core idle; ext read of addr 0x010 holding 0xDEADBEEF, accepted cycle 0 -> mem_rd=1 with addr 0x010 at cycle 1, ext_rvalid=1 with ext_rdata=0xDEADBEEF at cycle 2, core_stall never asserted.
- Core reads continuously; ext write 0x12345678 to 0x020 with MAX_WAIT=8 -> write issues at cycle 9 in FORCE, core_stall=1 for exactly cycle 9, a later read of 0x020 returns 0x12345678.
- Core access every other cycle -> the ext request issues on the first core-idle cycle, wait_cnt ≤ 1, core_stall stays 0.
- ext_rready held low for 5 cycles in RESP -> ext_rvalid and ext_rdata stable, ext_ready=0, core accesses unaffected.
- reset driven low while in PEND at wait_cnt=3 -> asynchronously ext_rvalid=0, ext_owner=0, core_stall=0, mem_rd=0 and mem_wr=0 during reset; on release ext_ready=1, and the dropped request produces no response.
- core_wr and ext_valid in the same IDLE cycle -> core write passes through to memory that cycle, ext captured, ext issues the next core-idle cycle.
